// File: rtl/lcd_ci_sequencer.sv
// Multi-cycle Nios II custom instruction that sequences HD44780 8-bit writes:
// init, single command, single data, and packed strings of up to four characters.
module lcd_ci_sequencer #(
  parameter int SETUP_CYC      = 2,
  parameter int PULSE_CYC      = 12,
  parameter int CMD_WAIT_CYC   = 50000,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        lcd_enable,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(SETUP_CYC, PULSE_CYC), max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_WAIT, S_DONE} state_t;

  // Byte idx of the operation; init mode ignores the payload entirely.
  function automatic logic [7:0] pick_byte(input logic [1:0] mode, input logic [31:0] payload,
                                           input logic [1:0] idx);
    logic [7:0] b;
    b = payload[{idx, 3'b000} +: 8];
    if (mode == 2'd0) begin
      case (idx)
        2'd0:    b = 8'h38;
        2'd1:    b = 8'h0C;
        2'd2:    b = 8'h06;
        default: b = 8'h01;
      endcase
    end
    return b;
  endfunction

  function automatic logic [1:0] last_index(input logic [31:0] opb);
    logic [1:0] li;
    case (opb[1:0])
      2'd0:    li = 2'd3;
      2'd3:    li = opb[3:2];
      default: li = 2'd0;
    endcase
    return li;
  endfunction

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, wait_last;
  logic [1:0]       idx, idx_nx, mode_q, last_idx_q;
  logic [31:0]      dataa_q;
  logic [7:0]       load_byte;
  logic             init_done, accept, load, finish;
  logic             unused_datab;

  assign unused_datab = ^datab[31:4];
  assign accept       = (state == S_IDLE) && start;

  // Clear/home need the long wait, but only when sent as commands.
  assign wait_last = ((mode_q == 2'd0 || mode_q == 2'd1) &&
                      (lcd_data == 8'h01 || lcd_data == 8'h02)) ? CLEAR_LAST : CMD_LAST;

  assign load_byte = accept ? pick_byte(datab[1:0], dataa, 2'd0)
                            : pick_byte(mode_q, dataa_q, idx_nx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       state <= S_IDLE;
    else if (clk_en) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    load     = 1'b0;
    finish   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_SETUP;
          cnt_nx   = '0;
          idx_nx   = 2'd0;
          load     = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nx = S_PULSE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_nx = S_WAIT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt == wait_last) begin
          cnt_nx = '0;
          if (idx == last_idx_q) begin
            state_nx = S_DONE;
            finish   = 1'b1;
          end else begin
            state_nx = S_SETUP;
            idx_nx   = idx + 2'd1;
            load     = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      mode_q     <= 2'd0;
      last_idx_q <= 2'd0;
      dataa_q    <= '0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      result     <= '0;
    end else if (clk_en) begin
      cnt <= cnt_nx;
      idx <= idx_nx;
      if (accept) begin
        mode_q     <= datab[1:0];
        dataa_q    <= dataa;
        last_idx_q <= last_index(datab);
        lcd_rs     <= datab[1];
      end
      if (load) lcd_data <= load_byte;
      if (finish) begin
        init_done <= init_done | (mode_q == 2'd0);
        result    <= {16'h0000, lcd_data, 1'b0, {1'b0, last_idx_q} + 3'd1, 3'b000,
                      init_done | (mode_q == 2'd0)};
      end
    end
  end

  assign done       = (state == S_DONE) && clk_en;
  assign lcd_enable = (state == S_PULSE);
  assign lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_ci_sequencer.sv
// Bench for lcd_ci_sequencer: a frame-list model of the expected pin activity per operation,
// compared every cycle, plus literal latency/result checks for the hand-worked cases.
module tb_lcd_ci_sequencer;
  localparam int S = 2, P = 3, CW = 10, CL = 20;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [31:0] dataa, datab, result;
  logic        done, lcd_enable, lcd_rs, lcd_rw;
  logic [7:0]  lcd_data;

  always #5 clk = ~clk;

  lcd_ci_sequencer #(.SETUP_CYC(S), .PULSE_CYC(P), .CMD_WAIT_CYC(CW), .CLEAR_WAIT_CYC(CL)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa), .datab(datab),
    .result(result), .done(done), .lcd_enable(lcd_enable), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data)
  );

  typedef struct packed {
    logic        en;
    logic        rs;
    logic [7:0]  data;
    logic        dn;
    logic [31:0] res;
  } frame_t;

  frame_t q[$];
  frame_t cur;
  logic   m_init;
  int     n_vec = 0, n_mis = 0, cyc = 0, acc_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur    = '0;
    m_init = 1'b0;
  endtask

  // Expand one operation into its per-cycle pin frames, ending with the done frame.
  task automatic build_op(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] bytes [4];
    int         n, w;
    logic       rs;
    frame_t     f;
    bytes = '{default: 8'h00};
    rs    = b[1];
    case (b[1:0])
      2'd0:    begin bytes = '{8'h38, 8'h0C, 8'h06, 8'h01}; n = 4; end
      2'd3:    begin n = int'(b[3:2]) + 1; for (int i = 0; i < 4; i++) bytes[i] = a[8*i +: 8]; end
      default: begin bytes[0] = a[7:0]; n = 1; end
    endcase
    for (int i = 0; i < n; i++) begin
      w = (b[1:0] < 2 && (bytes[i] == 8'h01 || bytes[i] == 8'h02)) ? CL : CW;
      for (int j = 0; j < S + P + w; j++) begin
        f.en = (j >= S && j < S + P); f.rs = rs; f.data = bytes[i]; f.dn = 1'b0; f.res = cur.res;
        q.push_back(f);
      end
    end
    if (b[1:0] == 2'd0) m_init = 1'b1;
    f.en  = 1'b0; f.rs = rs; f.data = bytes[n-1]; f.dn = 1'b1;
    f.res = {16'h0000, bytes[n-1], 1'b0, 3'(n), 3'b000, m_init};
    q.push_back(f);
  endtask

  task automatic model_step();
    if (clk_en) begin
      if (q.size() > 0) cur = q.pop_front();
      else if (cur.dn) cur.dn = 1'b0;
      else if (start) begin
        build_op(dataa, datab);
        cur     = q.pop_front();
        acc_cyc = cyc;
      end
    end
  endtask

  task automatic compare_outputs();
    chk("pins", {21'd0, lcd_enable, lcd_rs, lcd_rw, lcd_data, done, result},
        {21'd0, cur.en, cur.rs, 1'b0, cur.data, cur.dn & clk_en, cur.res});
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!reset) model_step();
    #1;
    compare_outputs();
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res, input bit freeze);
    bit seen;
    int d;
    seen = 0; d = 0;
    dataa = a; datab = b; start = 1'b1;
    tick();
    start = 1'b0; dataa = $urandom; datab = $urandom;
    if (freeze) begin
      tick(); tick();
      chk({name, " enable before freeze"}, 64'(lcd_enable), 64'd1);
      clk_en = 1'b0;
      repeat (5) tick();
      chk({name, " enable during freeze"}, 64'(lcd_enable), 64'd1);
      clk_en = 1'b1;
    end
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (done === 1'b1) begin seen = 1; d = cyc; end
    end
    if (!seen) begin
      n_vec++; n_mis++;
      $display("FAIL %s timeout: no done in 400 cycles, expected latency %0d", name, exp_lat);
    end else begin
      chk({name, " latency"}, 64'(d - acc_cyc + 1), 64'(exp_lat));
      chk({name, " result"}, 64'(result), 64'(exp_res));
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; start = 1'b0; dataa = '0; datab = '0;
    model_reset();
    #1;
    compare_outputs();
    tick(); tick();
    #2 reset = 1'b0;
    clk_en = 1'b1;
    tick();

    run_op("init",      32'h0,        32'h0, 71, 32'h0000_0141, 0);
    run_op("data41",    32'h41,       32'h2, 16, 32'h0000_4111, 0);
    run_op("string4",   32'h44434241, 32'hF, 61, 32'h0000_4441, 0);
    run_op("cmd_clear", 32'h01,       32'h1, 26, 32'h0000_0111, 0);
    run_op("data01",    32'h01,       32'h2, 16, 32'h0000_0111, 0);
    run_op("cmd_home",  32'h02,       32'h1, 26, 32'h0000_0211, 0);
    run_op("cmd_plain", 32'h80,       32'h1, 16, 32'h0000_8011, 0);
    run_op("string2",   32'h00005A59, 32'h7, 31, 32'h0000_5A21, 0);
    run_op("freeze",    32'h41,       32'h2, 21, 32'h0000_4111, 1);

    for (int i = 0; i < 3000; i++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      start  = ($urandom_range(0, 3) == 0);
      dataa  = $urandom;
      datab  = $urandom;
      tick();
    end

    clk_en = 1'b1; start = 1'b0;
    for (int i = 0; i < 200 && (q.size() > 0 || cur.dn); i++) tick();
    tick();

    dataa = 32'h44434241; datab = 32'hF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    chk("reset enable", 64'(lcd_enable), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    repeat (3) tick();
    #2 reset = 1'b0;
    tick();
    run_op("after_reset", 32'h41, 32'h2, 16, 32'h0000_4110, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
